// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: reassembles WIDTH-bit words from a gated
// serial stream and presents them on a valid/ready port with a sticky overrun flag.
module sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       sdi,
  input  logic                       sdi_valid,
  output logic [WIDTH-1:0]           pdo,
  output logic                       pdo_valid,
  input  logic                       pdo_ready,
  output logic                       overrun,
  input  logic                       clr_ovr,
  output logic [$clog2(WIDTH):0]     bit_cnt,
  output logic                       busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] pdo_q;
  logic             pdo_valid_q;
  logic             overrun_q;
  logic [CW-1:0]    cnt_q;
  logic             capture;
  logic             complete;

  // start wins over sdi_valid, so a coincident bit is never captured
  always_comb begin
    sr_d     = MSB_FIRST ? {sr_q[WIDTH-2:0], sdi} : {sdi, sr_q[WIDTH-1:1]};
    capture  = (state_q == SHIFT) && sdi_valid && !start;
    complete = capture && (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      pdo_q       <= '0;
      pdo_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (start) begin
        state_q <= SHIFT;
        sr_q    <= '0;
        cnt_q   <= '0;
      end else if (capture) begin
        sr_q  <= sr_d;
        cnt_q <= complete ? '0 : cnt_q + 1'b1;
      end

      // A completed word is only dropped when the held word is not being consumed
      if (complete && (!pdo_valid_q || pdo_ready)) begin
        pdo_q       <= sr_d;
        pdo_valid_q <= 1'b1;
      end else if (pdo_valid_q && pdo_ready) begin
        pdo_valid_q <= 1'b0;
      end

      if (complete && pdo_valid_q && !pdo_ready) begin
        overrun_q <= 1'b1;
      end else if (clr_ovr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign pdo       = pdo_q;
  assign pdo_valid = pdo_valid_q;
  assign overrun   = overrun_q;
  assign bit_cnt   = cnt_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: one MSB-first and one LSB-first instance share stimulus,
// table-driven vectors plus hand sequences for overrun priority and async reset.
module tb_sipo_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, sdi, sdiValid, pdoReady, clrOvr;
  logic [3:0] pdoM, pdoL;
  logic       validM, validL, ovrM, ovrL, busyM, busyL;
  logic [2:0] cntM, cntL;

  int checks   = 0;
  int failures = 0;

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .reset(reset), .start(start), .sdi(sdi), .sdi_valid(sdiValid),
    .pdo(pdoM), .pdo_valid(validM), .pdo_ready(pdoReady), .overrun(ovrM),
    .clr_ovr(clrOvr), .bit_cnt(cntM), .busy(busyM)
  );

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .reset(reset), .start(start), .sdi(sdi), .sdi_valid(sdiValid),
    .pdo(pdoL), .pdo_valid(validL), .pdo_ready(pdoReady), .overrun(ovrL),
    .clr_ovr(clrOvr), .bit_cnt(cntL), .busy(busyL)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, d, sv, rdy, clr;
    logic [3:0] expMsb, expLsb;
    logic       expValid, expOvr;
    logic [2:0] expCnt;
    logic       expBusy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic d, logic sv, logic rdy, logic clr,
                              logic [3:0] em, logic [3:0] el, logic ev, logic eo,
                              logic [2:0] ec, logic eb);
    vec_t v;
    v.st = st; v.d = d; v.sv = sv; v.rdy = rdy; v.clr = clr;
    v.expMsb = em; v.expLsb = el; v.expValid = ev; v.expOvr = eo;
    v.expCnt = ec; v.expBusy = eb;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, clock, then sample 1 time unit after the edge
  task automatic applyStimulus(input logic st, input logic d, input logic sv,
                               input logic rdy, input logic clr);
    start = st; sdi = d; sdiValid = sv; pdoReady = rdy; clrOvr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic d, input int gap, input logic rdy);
    repeat (gap) applyStimulus(1'b0, 1'b1, 1'b0, rdy, 1'b0);
    applyStimulus(1'b0, d, 1'b1, rdy, 1'b0);
  endtask

  task automatic checkAll(input string tag, input logic [3:0] em, input logic [3:0] el,
                          input logic ev, input logic eo, input logic [2:0] ec, input logic eb);
    checkOutput({tag, ".pdoMsb"},   {4'h0, pdoM},   {4'h0, em});
    checkOutput({tag, ".pdoLsb"},   {4'h0, pdoL},   {4'h0, el});
    checkOutput({tag, ".valid"},    {6'h0, validM, validL}, {6'h0, ev, ev});
    checkOutput({tag, ".overrun"},  {6'h0, ovrM, ovrL},     {6'h0, eo, eo});
    checkOutput({tag, ".bitCnt"},   {2'h0, cntM, cntL},     {2'h0, ec, ec});
    checkOutput({tag, ".busy"},     {6'h0, busyM, busyL},   {6'h0, eb, eb});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sdi = 1'b0; sdiValid = 1'b0; pdoReady = 1'b0; clrOvr = 1'b0;
    #12;
    checkAll("reset", 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    reset = 1'b0;

    //               st d  sv rdy clr  msb   lsb   val ovr cnt busy
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 4'h0, 0, 0, 3'd0, 0)); // idle ignores sdi
    vecs.push_back(mk(1, 0, 0, 1, 0, 4'h0, 4'h0, 0, 0, 3'd0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 4'h0, 0, 0, 3'd1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'h0, 4'h0, 0, 0, 3'd2, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 4'h0, 0, 0, 3'd3, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'hB, 4'hD, 1, 0, 3'd0, 1)); // word 1011
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'hB, 4'hD, 0, 0, 3'd0, 1)); // consumed
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'hB, 4'hD, 0, 0, 3'd1, 1)); // back-pressure 1010
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'hB, 4'hD, 0, 0, 3'd2, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'hB, 4'hD, 0, 0, 3'd3, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'hA, 4'h5, 1, 0, 3'd0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'hA, 4'h5, 1, 0, 3'd1, 1)); // 0110 dropped
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'hA, 4'h5, 1, 0, 3'd2, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'hA, 4'h5, 1, 0, 3'd3, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'hA, 4'h5, 1, 1, 3'd0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'hA, 4'h5, 1, 0, 3'd0, 1)); // clr_ovr
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'hA, 4'h5, 0, 0, 3'd0, 1)); // consume 1010
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'hA, 4'h5, 0, 0, 3'd1, 1)); // 1010 then 0011
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'hA, 4'h5, 0, 0, 3'd2, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'hA, 4'h5, 0, 0, 3'd3, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'hA, 4'h5, 1, 0, 3'd0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'hA, 4'h5, 1, 0, 3'd1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'hA, 4'h5, 1, 0, 3'd2, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'hA, 4'h5, 1, 0, 3'd3, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'h3, 4'hC, 1, 0, 3'd0, 1)); // consume+load same edge
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'h3, 4'hC, 0, 0, 3'd0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'h3, 4'hC, 0, 0, 3'd1, 1)); // partial 11
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'h3, 4'hC, 0, 0, 3'd2, 1));
    vecs.push_back(mk(1, 0, 1, 1, 0, 4'h3, 4'hC, 0, 0, 3'd0, 1)); // start beats sdi_valid
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'h3, 4'hC, 0, 0, 3'd1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'h3, 4'hC, 0, 0, 3'd2, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'h3, 4'hC, 0, 0, 3'd3, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'h5, 4'hA, 1, 0, 3'd0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'h5, 4'hA, 0, 0, 3'd0, 1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].st, vecs[i].d, vecs[i].sv, vecs[i].rdy, vecs[i].clr);
      checkAll($sformatf("vec%0d", i), vecs[i].expMsb, vecs[i].expLsb, vecs[i].expValid,
               vecs[i].expOvr, vecs[i].expCnt, vecs[i].expBusy);
    end

    // Overrun set and clr_ovr on the same edge: set wins
    for (int i = 0; i < 4; i++) sendBit(1'b1, 0, 1'b0);
    checkAll("fill", 4'hF, 4'hF, 1'b1, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) sendBit(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkAll("setWins", 4'hF, 4'hF, 1'b1, 1'b1, 3'd0, 1'b1);

    // Gapped stream 1100 then 0011, reset asserted after bit 2 of the second word
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    sendBit(1'b1, 0, 1'b1);
    sendBit(1'b1, 1, 1'b1);
    sendBit(1'b0, 2, 1'b1);
    sendBit(1'b0, 3, 1'b0);
    checkAll("gapWord", 4'hC, 4'h3, 1'b1, 1'b1, 3'd0, 1'b1);
    sendBit(1'b0, 2, 1'b0);
    sendBit(1'b0, 3, 1'b0);
    checkAll("midWord", 4'hC, 4'h3, 1'b1, 1'b1, 3'd2, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkAll("asyncReset", 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) sendBit(1'b1, 0, 1'b0);
    checkAll("idleAfterReset", 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
